// File: rtl/bcd_down_timer.sv
// Four-digit BCD down-counter with IDLE/RUN/PAUSE/EXPIRED control and optional auto-reload.
// All outputs registered: effects of inputs are visible one clock after the sampling edge; no backpressure.
module bcd_down_timer #(
  parameter bit RELOAD = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  output logic [3:0]  q3,
  output logic [3:0]  q2,
  output logic [3:0]  q1,
  output logic [3:0]  q0,
  output logic        running,
  output logic        expired,
  output logic        expire_pulse,
  output logic        load_err
);

  typedef enum logic [1:0] {
    s_idle    = 2'd0,
    s_run     = 2'd1,
    s_pause   = 2'd2,
    s_expired = 2'd3
  } state_t;

  state_t      state, nstate;
  logic [15:0] count, ncount;
  logic [15:0] reload_reg, nreload;
  logic        nexp_pulse, nload_err;

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic bcd_ok(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Strict priority: only the highest-priority asserted request is acted on each cycle.
  always_comb begin
    nstate     = state;
    ncount     = count;
    nreload    = reload_reg;
    nexp_pulse = 1'b0;
    nload_err  = 1'b0;
    if (clear) begin
      ncount  = 16'h0000;
      nreload = 16'h0000;
      nstate  = s_idle;
    end else if (load) begin
      if (bcd_ok(load_val)) begin
        ncount  = load_val;
        nreload = load_val;
        nstate  = s_idle;
      end else begin
        nload_err = 1'b1;
      end
    end else if (pause) begin
      if (state == s_run) nstate = s_pause;
    end else if (start) begin
      if ((state == s_idle && count != 16'h0000) || state == s_pause) nstate = s_run;
    end else if (tick && state == s_run && count != 16'h0000) begin
      if (count == 16'h0001) begin
        nexp_pulse = 1'b1;
        if (RELOAD && reload_reg != 16'h0000) begin
          ncount = reload_reg;
        end else begin
          ncount = 16'h0000;
          nstate = s_expired;
        end
      end else begin
        ncount = bcd_dec(count);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= s_idle;
      count        <= 16'h0000;
      reload_reg   <= 16'h0000;
      running      <= 1'b0;
      expired      <= 1'b0;
      expire_pulse <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      state        <= nstate;
      count        <= ncount;
      reload_reg   <= nreload;
      running      <= (nstate == s_run);
      expired      <= (nstate == s_expired);
      expire_pulse <= nexp_pulse;
      load_err     <= nload_err;
    end
  end

  assign q3 = count[15:12];
  assign q2 = count[11:8];
  assign q1 = count[7:4];
  assign q0 = count[3:0];

endmodule
